// File: rtl/piso_tx_shifter.sv
// piso_tx_shifter
//   Parallel-in, serial-out transmitter. A word accepted through the
//   load_valid/load_ready handshake is sent one bit per clock on sout, each
//   bit qualified by a one-cycle capture strobe sout_en for the downstream
//   enable-gated capture element. An even-parity bit is optionally appended.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   din         word to send, sampled only on an accepted load
//   load_valid  a word is offered on din
//   load_ready  block can accept a word (decoded from state, IDLE only)
//   hold        downstream stall, freezes shifting while in SHIFT
//   sout        serial data bit (registered, holds last bit when idle)
//   sout_en     capture strobe, sout is valid while high (registered)
//   busy        frame in progress, SHIFT or DONE (registered)
//   done        one-cycle pulse after the last bit (registered)
//
// State table
//   state | meaning
//   IDLE  | waiting for a load, load_ready=1
//   SHIFT | presenting frame bits; counter = bits already strobed
//   DONE  | one-cycle done pulse, then back to IDLE
//
// Timing: a load accepted at edge E0 puts bit k on sout with sout_en=1 after
// edge E0+k+1, done after E0+N+1, and IDLE (load_ready) after E0+N+2, so
// the earliest following load is taken at edge E0+N+3.

module piso_tx_shifter #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0,
  parameter int PARITY    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             hold,
  output logic             sout,
  output logic             sout_en,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH + PARITY;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);
  localparam logic [CW-1:0] DLEN = CW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg, sreg_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             par, par_nx;
  logic             sout_nx, sout_en_nx, busy_nx, done_nx;
  logic             head_bit;
  logic [WIDTH-1:0] sreg_adv;

  // Bit leaving the shift register next, and the register after it leaves.
  assign head_bit = (LSB_FIRST != 0) ? sreg[0] : sreg[WIDTH-1];
  assign sreg_adv = (LSB_FIRST != 0) ? {1'b0, sreg[WIDTH-1:1]}
                                     : {sreg[WIDTH-2:0], 1'b0};

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sreg_nx    = sreg;
    cnt_nx     = cnt;
    par_nx     = par;
    sout_nx    = sout;
    sout_en_nx = 1'b0;
    done_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (load_valid) begin
          state_nx = SHIFT;
          sreg_nx  = din;
          par_nx   = ^din;
          cnt_nx   = '0;
        end
      end
      SHIFT: begin
        // hold freezes everything; the strobe simply stays low for that cycle
        if (!hold) begin
          if (cnt == LAST) begin
            state_nx = DONE;
            done_nx  = 1'b1;
          end else begin
            sout_en_nx = 1'b1;
            cnt_nx     = cnt + CW'(1);
            if (cnt < DLEN) begin
              sout_nx = head_bit;
              sreg_nx = sreg_adv;
            end else begin
              sout_nx = par;
            end
          end
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg    <= '0;
      cnt     <= '0;
      par     <= 1'b0;
      sout    <= 1'b0;
      sout_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      sreg    <= sreg_nx;
      cnt     <= cnt_nx;
      par     <= par_nx;
      sout    <= sout_nx;
      sout_en <= sout_en_nx;
      busy    <= busy_nx;
      done    <= done_nx;
    end
  end

endmodule

// File: tb/tb_piso_tx_shifter.sv
// Bench for piso_tx_shifter. Two instances run side by side:
//   u0: WIDTH=8, MSB first, no parity   (N=8)
//   u1: WIDTH=8, LSB first, even parity (N=9)
// A frame-level reference model (list of frame bits followed by a done slot,
// consumed one item per unheld cycle) predicts every output each cycle.

module tb_piso_tx_shifter;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din_a [2];
  logic       lv_a [2];
  logic       hold_a [2];
  logic       rdy [2];
  logic       so [2];
  logic       so_en [2];
  logic       bsy [2];
  logic       dn [2];

  piso_tx_shifter #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u0 (
    .clk(clk), .rst_n(rst_n), .din(din_a[0]), .load_valid(lv_a[0]),
    .load_ready(rdy[0]), .hold(hold_a[0]), .sout(so[0]),
    .sout_en(so_en[0]), .busy(bsy[0]), .done(dn[0]));

  piso_tx_shifter #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) u1 (
    .clk(clk), .rst_n(rst_n), .din(din_a[1]), .load_valid(lv_a[1]),
    .load_ready(rdy[1]), .hold(hold_a[1]), .sout(so[1]),
    .sout_en(so_en[1]), .busy(bsy[1]), .done(dn[1]));

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  int tcount = 0;

  // reference model
  int         lsb_cfg [2] = '{0, 1};
  int         par_cfg [2] = '{0, 1};
  int         m_mode [2];          // 0 idle, 1 in frame, 2 done cycle
  logic [8:0] m_fb [2];            // frame bits in send order, index 0 first
  int         m_pos [2];
  int         m_len [2];
  logic       e_sout [2];
  logic       e_en [2];
  logic       e_done [2];

  // observation
  logic [8:0] cap [2];
  int         ncap [2];
  int         done_t [2];

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] x0;   // u0 bits in send order, first bit at MSB
    logic [8:0] x1;   // u1 bits in send order, first bit at MSB
  } vec_t;

  vec_t tbl [4];

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, tcount);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_pos[i] = 0; m_len[i] = 0; m_fb[i] = '0;
      e_sout[i] = 1'b0; e_en[i] = 1'b0; e_done[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      e_en[i] = 1'b0;
      e_done[i] = 1'b0;
      case (m_mode[i])
        0: if (lv_a[i]) begin
          for (int k = 0; k < W; k++)
            m_fb[i][k] = (lsb_cfg[i] != 0) ? din_a[i][k] : din_a[i][W-1-k];
          m_fb[i][W] = ($countones(din_a[i]) % 2) == 1;
          m_len[i]  = W + par_cfg[i];
          m_pos[i]  = 0;
          m_mode[i] = 1;
        end
        1: if (!hold_a[i]) begin
          if (m_pos[i] < m_len[i]) begin
            e_sout[i] = m_fb[i][m_pos[i]];
            e_en[i]   = 1'b1;
            m_pos[i]++;
          end else begin
            m_mode[i] = 2;
            e_done[i] = 1'b1;
          end
        end
        default: m_mode[i] = 0;
      endcase
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("sout%0d", i), 32'(so[i]), 32'(e_sout[i]));
      check($sformatf("sout_en%0d", i), 32'(so_en[i]), 32'(e_en[i]));
      check($sformatf("done%0d", i), 32'(dn[i]), 32'(e_done[i]));
      check($sformatf("busy%0d", i), 32'(bsy[i]), 32'(m_mode[i] != 0));
      check($sformatf("load_ready%0d", i), 32'(rdy[i]), 32'(m_mode[i] == 0));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    tcount++;
    compare_all();
    for (int i = 0; i < 2; i++) begin
      if (so_en[i]) begin
        cap[i] = {cap[i][7:0], so[i]};
        ncap[i]++;
      end
      if (dn[i]) done_t[i] = tcount;
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 2; i++) begin
      cap[i] = '0; ncap[i] = 0; done_t[i] = -1000;
    end
  endtask

  // Load both instances at the same edge and check both complete frames.
  task automatic run_frame(vec_t v);
    int t0;
    din_a[0] = v.d0; din_a[1] = v.d1;
    lv_a[0] = 1'b1;  lv_a[1] = 1'b1;
    tick();
    t0 = tcount;
    lv_a[0] = 1'b0;  lv_a[1] = 1'b0;
    din_a[0] = 8'($urandom); din_a[1] = 8'($urandom);
    clear_obs();
    repeat (12) tick();
    check("frame_bits0", 32'(cap[0][7:0]), 32'(v.x0));
    check("frame_strobes0", 32'(ncap[0]), 32'd8);
    check("frame_bits1", 32'(cap[1]), 32'(v.x1));
    check("frame_strobes1", 32'(ncap[1]), 32'd9);
    check("done_latency0", 32'(done_t[0] - t0), 32'd9);
    check("done_latency1", 32'(done_t[1] - t0), 32'd10);
  endtask

  initial begin
    int t0, t1;
    logic [7:0] first_cap;
    int first_n;

    tbl[0] = '{d0: 8'hA5, d1: 8'h07, x0: 8'hA5, x1: 9'b111000001};
    tbl[1] = '{d0: 8'h3C, d1: 8'h80, x0: 8'h3C, x1: 9'b000000011};
    tbl[2] = '{d0: 8'hF0, d1: 8'hFF, x0: 8'hF0, x1: 9'b111111110};
    tbl[3] = '{d0: 8'h01, d1: 8'hA5, x0: 8'h01, x1: 9'b101001010};

    for (int i = 0; i < 2; i++) begin
      din_a[i] = '0; lv_a[i] = 1'b0; hold_a[i] = 1'b0;
    end
    model_reset();
    clear_obs();

    #12;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven frames
    for (int v = 0; v < 4; v++) run_frame(tbl[v]);

    // hold for 3 cycles after the 2nd bit of u0
    din_a[0] = 8'hF0; lv_a[0] = 1'b1;
    tick();
    t0 = tcount;
    lv_a[0] = 1'b0;
    clear_obs();
    tick(); tick();
    hold_a[0] = 1'b1;
    repeat (3) begin
      tick();
      check("hold_sout", 32'(so[0]), 32'd1);
      check("hold_sout_en", 32'(so_en[0]), 32'd0);
    end
    hold_a[0] = 1'b0;
    repeat (12) tick();
    check("hold_bits", 32'(cap[0][7:0]), 32'hF0);
    check("hold_strobes", 32'(ncap[0]), 32'd8);
    check("hold_done_latency", 32'(done_t[0] - t0), 32'd12);

    // load offered while busy, then back-to-back with load_valid held high
    din_a[0] = 8'hA5; lv_a[0] = 1'b1;
    tick();
    t0 = tcount;
    clear_obs();
    repeat (2) tick();
    din_a[0] = 8'h3C;
    t1 = -1;
    for (int j = 0; j < 20 && t1 < 0; j++) begin
      if (rdy[0]) begin
        tick();
        t1 = tcount;
        lv_a[0] = 1'b0;
      end else begin
        tick();
      end
    end
    first_cap = cap[0][7:0];
    first_n = ncap[0];
    check("busy_first_bits", 32'(first_cap), 32'hA5);
    check("busy_first_strobes", 32'(first_n), 32'd8);
    // N=8: N+2 edges lie between the two accepting edges
    check("b2b_accept_spacing", 32'(t1 - t0), 32'd11);
    lv_a[0] = 1'b0;
    clear_obs();
    repeat (12) tick();
    check("busy_second_bits", 32'(cap[0][7:0]), 32'h3C);
    check("busy_second_strobes", 32'(ncap[0]), 32'd8);

    // asynchronous reset after the 4th bit
    din_a[0] = 8'hA5; din_a[1] = 8'h07;
    lv_a[0] = 1'b1;   lv_a[1] = 1'b1;
    tick();
    lv_a[0] = 1'b0;   lv_a[1] = 1'b0;
    clear_obs();
    repeat (4) tick();
    check("pre_reset_sout_en", 32'(so_en[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    clear_obs();
    run_frame(tbl[0]);

    // randomized traffic
    for (int j = 0; j < 1500; j++) begin
      for (int i = 0; i < 2; i++) begin
        din_a[i]  = 8'($urandom);
        lv_a[i]   = ($urandom_range(0, 2) != 0);
        hold_a[i] = ($urandom_range(0, 3) == 0);
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
